// File: rtl/sysmgr_seq_pkg.sv
// Shared definitions for the audio PLL power-up / recovery sequencer.
package sysmgr_seq_pkg;

  // Sequencer states (3-bit encoding, also exported on the debug state port)
  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4,
    FAULT     = 3'd5
  } seq_state_t;

  // Failed-attempt counter width; the counter saturates at all-ones
  localparam int RETRY_W = 3;
  localparam logic [RETRY_W-1:0] RETRY_SAT = '1;

  // Largest of four cycle parameters, used to size the shared cycle counter
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/sysmgr_seq_sync_2ff.sv
// Generic two-flop synchroniser with synchronous reset to zero.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic [W-1:0] d_in,
  output logic [W-1:0] q_out
);

  logic [W-1:0] meta_q;

  // Two register stages; the first may go metastable, the second is clean
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      meta_q <= '0;
      q_out  <= '0;
    end else begin
      meta_q <= d_in;
      q_out  <= meta_q;
    end
  end

endmodule

// File: rtl/sysmgr_seq.sv
// Audio PLL power-up / recovery sequencer: pulses the PLL reset, waits for a
// stable lock (with timeout and bounded retries), releases the downstream
// resets one stage at a time, then watches lock in RUN and re-sequences on loss.
// soft_rst_req is a single-cycle pulse with no handshake; it is acted on at the
// edge where it is sampled high and overrides every other event on that edge.
module sysmgr_seq
  import sysmgr_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 4096,
  parameter int STABLE_CYCLES  = 128,
  parameter int MAX_RETRIES    = 3,
  parameter int N_STAGES       = 3,
  parameter int STAGE_GAP      = 32,
  parameter int GLITCH_FILT    = 4
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                pll_lock_in,
  input  logic                soft_rst_req,
  output logic                pll_rst_out,
  output logic [N_STAGES-1:0] rst_stage_out,
  output logic                rst_out,
  output logic                ready_out,
  output logic                fault_out,
  output logic [RETRY_W-1:0]  retry_cnt_out,
  output seq_state_t          state_out
);

  localparam int CNT_MAX = max4(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, STAGE_GAP);
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int LOW_W   = $clog2(GLITCH_FILT) + 1;

  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP - 1);
  localparam logic [LOW_W-1:0] LOW_LAST     = LOW_W'(GLITCH_FILT - 1);

  logic                lock_s;
  logic [CNT_W-1:0]    cnt;
  logic [LOW_W-1:0]    low_cnt;
  logic                in_lock_watch;
  logic                lock_lost;
  logic [N_STAGES-1:0] stage_shift;
  logic [RETRY_W-1:0]  retry_inc;
  logic                retry_exhausted;

  sync_2ff #(.W(1)) u_lock_sync (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .d_in   (pll_lock_in),
    .q_out  (lock_s)
  );

  // Lock is only supervised once resets have started to come out
  assign in_lock_watch = (state_out == RELEASE) || (state_out == RUN);
  assign lock_lost     = in_lock_watch && !lock_s && (low_cnt == LOW_LAST);

  // Next stage mask: bit 0 releases first, so zeros enter from the bottom
  assign stage_shift = rst_stage_out << 1;

  assign retry_inc       = (retry_cnt_out == RETRY_SAT) ? RETRY_SAT : retry_cnt_out + RETRY_W'(1);
  assign retry_exhausted = (32'(retry_inc) > MAX_RETRIES);

  // Lock-low filter: counts consecutive low lock cycles in RELEASE/RUN
  always_ff @(posedge clk_in) begin
    if (rst_in || soft_rst_req) begin
      low_cnt <= '0;
    end else if (in_lock_watch && !lock_s && !lock_lost) begin
      low_cnt <= low_cnt + LOW_W'(1);
    end else begin
      low_cnt <= '0;
    end
  end

  // Sequencer FSM with the shared cycle counter and all registered outputs
  always_ff @(posedge clk_in) begin
    if (rst_in || soft_rst_req) begin
      state_out     <= PLL_RST;
      cnt           <= '0;
      pll_rst_out   <= 1'b1;
      rst_stage_out <= '1;
      rst_out       <= 1'b1;
      ready_out     <= 1'b0;
      fault_out     <= 1'b0;
      retry_cnt_out <= '0;
    end else begin
      case (state_out)
        PLL_RST: begin
          if (cnt == PLL_RST_LAST) begin
            state_out   <= WAIT_LOCK;
            cnt         <= '0;
            pll_rst_out <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        WAIT_LOCK: begin
          if (lock_s) begin
            state_out <= STABLE;
            cnt       <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            cnt           <= '0;
            retry_cnt_out <= retry_inc;
            pll_rst_out   <= 1'b1;
            if (retry_exhausted) begin
              state_out <= FAULT;
              fault_out <= 1'b1;
            end else begin
              state_out <= PLL_RST;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        STABLE: begin
          // Any low cycle restarts the lock wait without charging a retry
          if (!lock_s) begin
            state_out <= WAIT_LOCK;
            cnt       <= '0;
          end else if (cnt == STABLE_LAST) begin
            state_out <= RELEASE;
            cnt       <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RELEASE: begin
          if (lock_lost) begin
            state_out     <= PLL_RST;
            cnt           <= '0;
            pll_rst_out   <= 1'b1;
            rst_stage_out <= '1;
            rst_out       <= 1'b1;
          end else begin
            // cnt wraps every STAGE_GAP cycles; one stage is released per wrap
            cnt <= (cnt == GAP_LAST) ? '0 : cnt + CNT_W'(1);
            if (cnt == '0) begin
              rst_stage_out <= stage_shift;
              rst_out       <= |stage_shift;
              if (stage_shift == '0) begin
                state_out     <= RUN;
                cnt           <= '0;
                ready_out     <= 1'b1;
                retry_cnt_out <= '0;
              end
            end
          end
        end

        RUN: begin
          if (lock_lost) begin
            state_out     <= PLL_RST;
            cnt           <= '0;
            pll_rst_out   <= 1'b1;
            rst_stage_out <= '1;
            rst_out       <= 1'b1;
            ready_out     <= 1'b0;
          end
        end

        FAULT: begin
          pll_rst_out   <= 1'b1;
          rst_stage_out <= '1;
          rst_out       <= 1'b1;
          ready_out     <= 1'b0;
          fault_out     <= 1'b1;
        end

        default: begin
          state_out     <= PLL_RST;
          cnt           <= '0;
          pll_rst_out   <= 1'b1;
          rst_stage_out <= '1;
          rst_out       <= 1'b1;
          ready_out     <= 1'b0;
          fault_out     <= 1'b0;
        end
      endcase
    end
  end

endmodule
